dpd_digit_serializer: RTL and testbench
=======================================

// Module: dpd_digit_serializer
// PURPOSE
//   Downstream consumer of packed DPD declets. Accepts a valid/ready stream of
//   10-bit densely-packed-decimal declets and emits their BCD digits one per
//   cycle, most significant first, on a valid/ready digit stream. A group of
//   DECLETS_PER_GRP declets forms one decimal number. Feeds the digit display
//   and serial-output path.
// PARAMETERS
//   DECLETS_PER_GRP  2  declets per number (1..8); group = 3*DECLETS_PER_GRP digits
//   LZ_SUPPRESS      1  1 = drop leading zero digits of each group; 0 = emit all
// PORTS
//   clk          in   1   clock, all state on rising edge
//   rst          in   1   synchronous reset, active high
//   in_dpd       in   10  declet, bits [9:0]
//   in_valid     in   1   in_dpd valid
//   in_ready     out  1   block accepts in_dpd this cycle
//   out_digit    out  4   BCD digit 0..9
//   out_valid    out  1   out_digit valid
//   out_ready    in   1   sink accepts out_digit this cycle
//   out_last     out  1   final digit of the group (qualified by out_valid)
//   out_noncanon out  1   digit comes from a non-canonical declet
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): FSM->IDLE, digit idx=2, declet cnt=0, seen_nz=0;
//     out_valid=0, in_ready=1, out_digit=0, out_last=0, out_noncanon=0.
//   - Decode via dpd_unpack instance on the holding register; registered outputs.
//   - Non-canonical: hold[3:1]==3'b111 && hold[6:5]==2'b11 && hold[9:8]!=2'b00
//     (24 codes); decode as usual, flag all 3 digits of that declet.
//   - FSM IDLE: in_ready=1; on in_valid&in_ready load hold reg, idx=2 -> EMIT.
//   - FSM EMIT: one digit slot per cycle, idx 2 (hundreds) -> 1 -> 0.
//     Slot advances when: digit emitted and out_ready=1, or digit suppressed.
//     out_valid=0 during a suppressed slot; out_ready=0 stalls slot, all outputs stable.
//   - Suppression (LZ_SUPPRESS=1): digit suppressed iff digit==0, seen_nz=0 and
//     not the last slot of group. First nonzero sets seen_nz. All-zero group
//     emits exactly one '0' with out_last=1.
//   - out_last=1 on idx=0 slot of declet cnt==DECLETS_PER_GRP-1; on its
//     acceptance cnt->0, seen_nz->0. Otherwise after idx=0, cnt increments.
//   - in_ready also 1 in EMIT during the idx=0 slot when it advances this cycle;
//     a new declet then loads with no bubble. Throughput 3 cycles/declet.
//     If no in_valid at that point -> IDLE.
//   - Latency: declet accepted at edge t -> first slot (digit 2) visible after t+1.
//   - in_ready is a function of registered state and out_ready only; no path
//     from in_valid to in_ready.
//   - Reset mid-group discards hold reg and partial group; next declet starts
//     a fresh group (cnt=0).
//   - in_dpd ignored when in_ready=0; in_valid may drop without penalty.
// TESTING
//   1 rst=1 two cycles -> out_valid=0, in_ready=1, out_last=0; hold rst, drive
//     in_valid -> nothing accepted.
//   2 LZ_SUPPRESS=0, out_ready=1, declets 0x0A3 then 0x0FF back-to-back ->
//     digits 1,2,3,9,9,9 on 6 consecutive cycles, out_last only on 6th,
//     in_ready high on cycle of digit 3.
//   3 LZ_SUPPRESS=1, declets 0x000, 0x007 -> single digit 7 with out_last=1
//     after 5 silent slots; declets 0x000,0x000 -> single 0, out_last=1.
//   4 out_ready=0 for 4 cycles while digit 2 presented -> out_digit=2,
//     out_valid=1 held stable, in_ready=0; release -> sequence resumes, no loss.
//   5 declet 0x3FF -> digits 9,9,9 with out_noncanon=1; 0x0FF -> 9,9,9, flag 0.
//   6 rst=1 after first digit of 0x0A3 -> next out_valid only after new declet;
//     following group counts from cnt=0 (out_last on its 6th digit).

Source files
------------

// File: rtl/dpd_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dpd_digit_serializer (with helper dpd_unpack)
// Brief    : Streams 10-bit DPD declets out as BCD digits, MS digit first,
//            with optional leading-zero suppression per group of declets.
// Revision : 1.0 - initial release
// ============================================================================

module dpd_unpack (
    input  logic [9:0] i_dpd,
    output logic [3:0] o_d2,
    output logic [3:0] o_d1,
    output logic [3:0] o_d0,
    output logic       o_noncanon
);
    always_comb begin
        o_d2 = {1'b0, i_dpd[9:7]};
        o_d1 = {1'b0, i_dpd[6:4]};
        o_d0 = {1'b0, i_dpd[2:0]};
        if (i_dpd[3]) begin
            case (i_dpd[2:1])
                2'b00: o_d0 = {3'b100, i_dpd[0]};
                2'b01: begin
                    o_d1 = {3'b100, i_dpd[4]};
                    o_d0 = {1'b0, i_dpd[6:5], i_dpd[0]};
                end
                2'b10: begin
                    o_d2 = {3'b100, i_dpd[7]};
                    o_d0 = {1'b0, i_dpd[9:8], i_dpd[0]};
                end
                default: begin
                    // Two or three large digits: bits [6:5] say which ones.
                    case (i_dpd[6:5])
                        2'b00: begin
                            o_d2 = {3'b100, i_dpd[7]};
                            o_d1 = {3'b100, i_dpd[4]};
                            o_d0 = {1'b0, i_dpd[9:8], i_dpd[0]};
                        end
                        2'b01: begin
                            o_d2 = {3'b100, i_dpd[7]};
                            o_d1 = {1'b0, i_dpd[9:8], i_dpd[4]};
                            o_d0 = {3'b100, i_dpd[0]};
                        end
                        2'b10: begin
                            o_d1 = {3'b100, i_dpd[4]};
                            o_d0 = {3'b100, i_dpd[0]};
                        end
                        default: begin
                            o_d2 = {3'b100, i_dpd[7]};
                            o_d1 = {3'b100, i_dpd[4]};
                            o_d0 = {3'b100, i_dpd[0]};
                        end
                    endcase
                end
            endcase
        end
    end

    assign o_noncanon = (i_dpd[3:1] == 3'b111) && (i_dpd[6:5] == 2'b11) && (i_dpd[9:8] != 2'b00);
endmodule

module dpd_digit_serializer #(
    parameter int DECLETS_PER_GRP = 2,
    parameter int LZ_SUPPRESS     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] in_dpd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_digit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       out_noncanon
);
    localparam int c_CNT_W = (DECLETS_PER_GRP > 1) ? $clog2(DECLETS_PER_GRP) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(DECLETS_PER_GRP - 1);
    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_EMIT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [9:0]         r_hold;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_seen_nz;

    logic [3:0] w_d2, w_d1, w_d0, w_digit;
    logic       w_noncanon, w_last_slot, w_suppress, w_advance, w_load;

    dpd_unpack u_unpack (
        .i_dpd      (r_hold),
        .o_d2       (w_d2),
        .o_d1       (w_d1),
        .o_d0       (w_d0),
        .o_noncanon (w_noncanon)
    );

    assign w_digit     = (r_idx == 2'd2) ? w_d2 : (r_idx == 2'd1) ? w_d1 : w_d0;
    assign w_last_slot = (r_idx == 2'd0) && (r_cnt == c_LAST_CNT);

    generate
        if (LZ_SUPPRESS != 0) begin : g_lz
            assign w_suppress = (w_digit == 4'd0) && !r_seen_nz && !w_last_slot;
        end else begin : g_no_lz
            assign w_suppress = 1'b0;
        end
    endgenerate

    // A suppressed slot advances on its own; a real digit waits for the sink.
    assign w_advance = (r_state == c_S_EMIT) && (w_suppress || out_ready);
    assign w_load    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (in_valid) w_state_nxt = c_S_EMIT;
            c_S_EMIT: if (w_advance && (r_idx == 2'd0) && !in_valid) w_state_nxt = c_S_IDLE;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_digit    = 4'd0;
        out_last     = 1'b0;
        out_noncanon = 1'b0;
        case (r_state)
            c_S_IDLE: in_ready = 1'b1;
            c_S_EMIT: begin
                in_ready     = w_advance && (r_idx == 2'd0);
                out_valid    = !w_suppress;
                out_digit    = w_digit;
                out_last     = !w_suppress && w_last_slot;
                out_noncanon = !w_suppress && w_noncanon;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold    <= 10'd0;
            r_idx     <= 2'd2;
            r_cnt     <= '0;
            r_seen_nz <= 1'b0;
        end else begin
            if (w_load) begin
                r_hold <= in_dpd;
                r_idx  <= 2'd2;
            end else if (w_advance && (r_idx != 2'd0)) begin
                r_idx <= r_idx - 2'd1;
            end
            if (w_advance) begin
                if (w_last_slot) begin
                    r_cnt     <= '0;
                    r_seen_nz <= 1'b0;
                end else begin
                    if (r_idx == 2'd0) r_cnt <= r_cnt + 1'b1;
                    if (!w_suppress && (w_digit != 4'd0)) r_seen_nz <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dpd_digit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpd_digit_serializer
// Brief    : Self-checking bench; drives one LZ_SUPPRESS=0 and one =1 instance.
// Revision : 1.0 - initial release
// ============================================================================

module tb_dpd_digit_serializer;
    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, sel;
    logic [9:0] in_dpd;
    logic       in_valid0, in_valid1;
    logic       in_ready0, out_valid0, out_last0, out_nc0;
    logic       in_ready1, out_valid1, out_last1, out_nc1;
    logic [3:0] out_digit0, out_digit1;
    logic       cur_in_ready, cur_out_valid, cur_out_last, cur_out_nc;
    logic [3:0] cur_out_digit;

    assign in_valid0     = in_valid & ~sel;
    assign in_valid1     = in_valid & sel;
    assign cur_in_ready  = sel ? in_ready1  : in_ready0;
    assign cur_out_valid = sel ? out_valid1 : out_valid0;
    assign cur_out_last  = sel ? out_last1  : out_last0;
    assign cur_out_nc    = sel ? out_nc1    : out_nc0;
    assign cur_out_digit = sel ? out_digit1 : out_digit0;

    dpd_digit_serializer #(.DECLETS_PER_GRP(N), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst(rst), .in_dpd(in_dpd), .in_valid(in_valid0), .in_ready(in_ready0),
        .out_digit(out_digit0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_last(out_last0), .out_noncanon(out_nc0));

    dpd_digit_serializer #(.DECLETS_PER_GRP(N), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst(rst), .in_dpd(in_dpd), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_digit(out_digit1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_last(out_last1), .out_noncanon(out_nc1));

    always #5 clk = ~clk;

    typedef struct { logic [9:0] dpd; logic [3:0] d2, d1, d0; logic nc; } vec_t;
    typedef struct { logic [3:0] d; logic l; logic nc; } dig_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   dec_val[1024];
    bit   dec_ok[1024];
    logic [9:0] acc_q[$];
    dig_t exp_q[$];
    dig_t act_q[$];
    bit   done;
    vec_t tbl[14];

    task automatic chk(input string nm, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    // Canonical BCD->DPD encoder; its inverse is the reference decoder.
    function automatic logic [9:0] enc(input int n);
        logic [3:0] a, b, c;
        a = 4'(n / 100);
        b = 4'((n / 10) % 10);
        c = 4'(n % 10);
        case ({a[3], b[3], c[3]})
            3'b000:  return {a[2:0], b[2:0], 1'b0, c[2:0]};
            3'b001:  return {a[2:0], b[2:0], 1'b1, 2'b00, c[0]};
            3'b010:  return {a[2:0], c[2:1], b[0], 1'b1, 2'b01, c[0]};
            3'b011:  return {a[2:0], 2'b10, b[0], 1'b1, 2'b11, c[0]};
            3'b100:  return {c[2:1], a[0], b[2:0], 1'b1, 2'b10, c[0]};
            3'b101:  return {b[2:1], a[0], 2'b01, b[0], 1'b1, 2'b11, c[0]};
            3'b110:  return {c[2:1], a[0], 2'b00, b[0], 1'b1, 2'b11, c[0]};
            default: return {2'b00, a[0], 2'b11, b[0], 1'b1, 2'b11, c[0]};
        endcase
    endfunction

    function automatic int declet_value(input logic [9:0] d);
        if (dec_ok[d]) return dec_val[d];
        return (8 + int'(d[7])) * 100 + (8 + int'(d[4])) * 10 + (8 + int'(d[0]));
    endfunction

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_declet(input logic [9:0] d);
        int ok = 0;
        in_valid = 1'b1;
        in_dpd   = d;
        for (int t = 0; t < 40 && ok == 0; t++) begin
            @(negedge clk);
            if (cur_in_ready) begin
                ok = 1;
                acc_q.push_back(d);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (ok == 0) chk("send_timeout", ok, 1);
    endtask

    task automatic get_digit(output dig_t r);
        int ok = 0;
        r = '{4'd15, 1'b0, 1'b0};
        for (int t = 0; t < 40 && ok == 0; t++) begin
            @(negedge clk);
            if (cur_out_valid && out_ready) begin
                ok = 1;
                r = '{cur_out_digit, cur_out_last, cur_out_nc};
            end
            @(posedge clk); #1;
        end
        if (ok == 0) chk("digit_timeout", ok, 1);
    endtask

    task automatic run_pair(input string nm, input logic [9:0] a, input logic [9:0] b,
                            input logic [23:0] e_dig, input logic [5:0] e_val,
                            input logic [5:0] e_last, input logic [5:0] e_nc,
                            input logic [5:0] e_rdy);
        in_valid = 1'b1;
        in_dpd   = a;
        @(negedge clk);
        chk({nm, "_accept"}, int'(cur_in_ready), 1);
        @(posedge clk); #1;
        in_dpd = b;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("%s_valid%0d", nm, k), int'(cur_out_valid), int'(e_val[5-k]));
            chk($sformatf("%s_rdy%0d", nm, k), int'(cur_in_ready), int'(e_rdy[5-k]));
            if (e_val[5-k]) begin
                chk($sformatf("%s_digit%0d", nm, k), int'(cur_out_digit), int'(e_dig[23-4*k -: 4]));
                chk($sformatf("%s_last%0d", nm, k), int'(cur_out_last), int'(e_last[5-k]));
                chk($sformatf("%s_nc%0d", nm, k), int'(cur_out_nc), int'(e_nc[5-k]));
            end
            @(posedge clk); #1;
            if (k == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        chk({nm, "_idle"}, int'(cur_out_valid), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_run(input logic s, input int ngroups);
        int p10[6] = '{100000, 10000, 1000, 100, 10, 1};
        acc_q.delete();
        exp_q.delete();
        act_q.delete();
        done = 1'b0;
        sel  = s;
        fork
            begin
                for (int i = 0; i < 2 * ngroups; i++) begin
                    int r = int'($urandom_range(0, 5));
                    logic [9:0] d;
                    if (r < 2)       d = 10'd0;
                    else if (r == 2) d = 10'($urandom_range(0, 7));
                    else             d = 10'($urandom_range(0, 1023));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_declet(d);
                end
                // Model: each group is a 6-digit decimal number.
                for (int g = 0; g + 1 < acc_q.size(); g += 2) begin
                    int val = declet_value(acc_q[g]) * 1000 + declet_value(acc_q[g+1]);
                    int start = 0;
                    if (s) begin
                        start = 5;
                        for (int p = 4; p >= 0; p--) if ((val / p10[p]) % 10 != 0) start = p;
                    end
                    for (int p = start; p < 6; p++) begin
                        dig_t e;
                        e.d  = 4'((val / p10[p]) % 10);
                        e.l  = (p == 5);
                        e.nc = (p < 3) ? !dec_ok[acc_q[g]] : !dec_ok[acc_q[g+1]];
                        exp_q.push_back(e);
                    end
                end
                for (int t = 0; t < 600 && act_q.size() < exp_q.size(); t++) @(posedge clk);
                repeat (10) @(posedge clk);
                #1 done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (cur_out_valid && out_ready)
                        act_q.push_back('{cur_out_digit, cur_out_last, cur_out_nc});
                end
            end
        join
        out_ready = 1'b1;
        chk($sformatf("rand%0d_len", s), act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("rand%0d_digit[%0d]", s, i), int'(act_q[i].d), int'(exp_q[i].d));
            chk($sformatf("rand%0d_last[%0d]", s, i), int'(act_q[i].l), int'(exp_q[i].l));
            chk($sformatf("rand%0d_nc[%0d]", s, i), int'(act_q[i].nc), int'(exp_q[i].nc));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        dig_t r;
        tbl[0]  = '{10'h0A3, 4'd1, 4'd2, 4'd3, 1'b0};
        tbl[1]  = '{10'h0FF, 4'd9, 4'd9, 4'd9, 1'b0};
        tbl[2]  = '{10'h3FF, 4'd9, 4'd9, 4'd9, 1'b1};
        tbl[3]  = '{10'h000, 4'd0, 4'd0, 4'd0, 1'b0};
        tbl[4]  = '{10'h007, 4'd0, 4'd0, 4'd7, 1'b0};
        tbl[5]  = '{10'h009, 4'd0, 4'd0, 4'd9, 1'b0};
        tbl[6]  = '{10'h00B, 4'd0, 4'd8, 4'd1, 1'b0};
        tbl[7]  = '{10'h00D, 4'd8, 4'd0, 4'd1, 1'b0};
        tbl[8]  = '{10'h00E, 4'd8, 4'd8, 4'd0, 1'b0};
        tbl[9]  = '{10'h02E, 4'd8, 4'd0, 4'd8, 1'b0};
        tbl[10] = '{10'h04E, 4'd0, 4'd8, 4'd8, 1'b0};
        tbl[11] = '{10'h16E, 4'd8, 4'd8, 4'd8, 1'b1};
        tbl[12] = '{10'h06E, 4'd8, 4'd8, 4'd8, 1'b0};
        tbl[13] = '{10'h3A5, 4'd7, 4'd2, 4'd5, 1'b0};
        for (int i = 0; i < 1024; i++) begin dec_ok[i] = 1'b0; dec_val[i] = 0; end
        for (int n = 0; n < 1000; n++) begin dec_ok[enc(n)] = 1'b1; dec_val[enc(n)] = n; end

        // Reset holds everything idle even with in_valid asserted.
        rst = 1'b1; sel = 1'b0; in_valid = 1'b1; in_dpd = 10'h123; out_ready = 1'b1; done = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("rst_valid0", int'(out_valid0), 0);
            chk("rst_ready0", int'(in_ready0), 1);
            chk("rst_last0", int'(out_last0), 0);
            chk("rst_digit0", int'(out_digit0), 0);
            chk("rst_valid1", int'(out_valid1), 0);
            chk("rst_ready1", int'(in_ready1), 1);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", int'(out_valid0), 0);
        @(posedge clk); #1;

        // Decode table through the non-suppressing instance.
        for (int i = 0; i < 14; i++) begin
            send_declet(tbl[i].dpd);
            for (int k = 0; k < 3; k++) begin
                get_digit(r);
                chk($sformatf("tbl%0d_digit%0d", i, k), int'(r.d),
                    int'((k == 0) ? tbl[i].d2 : (k == 1) ? tbl[i].d1 : tbl[i].d0));
                chk($sformatf("tbl%0d_last%0d", i, k), int'(r.l), int'(k == 2 && (i % 2) == 1));
                chk($sformatf("tbl%0d_nc%0d", i, k), int'(r.nc), int'(tbl[i].nc));
            end
        end

        do_reset(); sel = 1'b0;
        run_pair("b2b_lz0", 10'h0A3, 10'h0FF, 24'h123999, 6'b111111, 6'b000001, 6'b000000, 6'b001001);
        run_pair("nc_lz0", 10'h3FF, 10'h0FF, 24'h999999, 6'b111111, 6'b000001, 6'b111000, 6'b001001);
        do_reset(); sel = 1'b1;
        run_pair("lz_7", 10'h000, 10'h007, 24'h000007, 6'b000001, 6'b000001, 6'b000000, 6'b001001);
        run_pair("lz_0", 10'h000, 10'h000, 24'h000000, 6'b000001, 6'b000001, 6'b000000, 6'b001001);
        run_pair("lz_5000", 10'h005, 10'h000, 24'h005000, 6'b001111, 6'b000001, 6'b000000, 6'b001001);
        run_pair("b2b_lz1", 10'h0A3, 10'h0FF, 24'h123999, 6'b111111, 6'b000001, 6'b000000, 6'b001001);

        // Back-pressure on the middle digit with the next declet waiting.
        do_reset(); sel = 1'b0;
        in_valid = 1'b1; in_dpd = 10'h0A3;
        @(posedge clk); #1;
        in_dpd = 10'h0FF;
        @(negedge clk);
        chk("stall_d1", int'(cur_out_digit), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stall_digit%0d", k), int'(cur_out_digit), 2);
            chk($sformatf("stall_valid%0d", k), int'(cur_out_valid), 1);
            chk($sformatf("stall_rdy%0d", k), int'(cur_in_ready), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_resume_d2", int'(cur_out_digit), 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_d3", int'(cur_out_digit), 3);
        chk("stall_d3_rdy", int'(cur_in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall_9_%0d", k), int'(cur_out_digit), 9);
            chk($sformatf("stall_last%0d", k), int'(cur_out_last), int'(k == 2));
            @(posedge clk); #1;
        end

        // Reset in the middle of the second declet of a group.
        do_reset(); sel = 1'b0;
        in_valid = 1'b1; in_dpd = 10'h0A3;
        @(posedge clk); #1;
        in_dpd = 10'h0FF;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_pre_digit", int'(cur_out_digit), 9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_valid%0d", k), int'(cur_out_valid), 0);
            chk($sformatf("midrst_rdy%0d", k), int'(cur_in_ready), 1);
            @(posedge clk); #1;
        end
        run_pair("after_rst", 10'h0A3, 10'h0FF, 24'h123999, 6'b111111, 6'b000001, 6'b000000, 6'b001001);

        do_reset();
        rand_run(1'b0, 40);
        do_reset();
        rand_run(1'b1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
